// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
//   Shares one iterative 32-bit Booth multiplier core between N_REQ requesters.
//   Round-robin grant on the request side and a single held response channel.
//   The core is run through CLEAR -> SETTLE -> RUN for every operation, and the
//   64-bit product is held until the consumer takes it.
//
//   Optional feature macro: BOOTH_ARB_TIMEOUT_EN
//     defined   : RUN-phase watchdog of TIMEOUT_CYC cycles plus a sticky error
//                 flag that is ORed into rsp_err until the next reset.
//     undefined : no watchdog, RUN waits for mul_done forever, rsp_err = 0.
//
//   Handshake rule (request and response channels alike): a transfer happens
//   on a rising clk edge where valid and ready are both 1. req_ready is one-hot
//   and only ever asserted in IDLE. rsp_valid stays high, with rsp_id,
//   rsp_result and rsp_err stable, until that edge.
module booth_mult_arbiter #(
  parameter int N_REQ       = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_result,
  output logic                 rsp_err,
  output logic [31:0]          mul_m,
  output logic [31:0]          mul_q,
  output logic                 mul_en,
  output logic                 mul_clr,
  input  logic [63:0]          mul_result,
  input  logic                 mul_done,
  output logic                 busy
);

  localparam int CW = IDW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_found;
  logic [CW-1:0]   cand;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic            run_timeout;

  logic [31:0]     a_arr [N_REQ];
  logic [31:0]     b_arr [N_REQ];

  // Split the flat operand buses into one word per requester.
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end

  // Round-robin scan starting just after the last granted requester, with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; RUN exits only on mul_done (or the watchdog when built in).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (gnt_found) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_RUN;
      S_RUN:    if (mul_done || run_timeout) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode. The grant is also masked by reset so every output reads 0
  // while reset is held, whatever the requesters are driving.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    mul_en    = 1'b0;
    mul_clr   = 1'b0;
    case (state)
      S_IDLE:   if (gnt_found && reset) req_ready[gnt_idx] = 1'b1;
      S_CLEAR:  begin
        mul_en  = 1'b1;
        mul_clr = 1'b1;
      end
      S_SETTLE: mul_en = 1'b1;
      S_RUN:    mul_en = 1'b1;
      S_RESP:   rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign mul_m = op_a;
  assign mul_q = op_b;

  // Operand/ID capture on the request handshake and product capture at the end of RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= IDW'(N_REQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      if (state == S_IDLE && gnt_found) begin
        op_a       <= a_arr[gnt_idx];
        op_b       <= b_arr[gnt_idx];
        rsp_id     <= gnt_idx;
        last_grant <= gnt_idx;
      end
      if (state == S_RUN && mul_done) rsp_result <= mul_result;
      else if (run_timeout)           rsp_result <= '0;
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          sticky_err;
  logic          rsp_err_q;

  // Fires in the TIMEOUT_CYC-th RUN cycle when the core still has not finished.
  assign run_timeout = (state == S_RUN) && !mul_done && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign rsp_err     = rsp_err_q;

  // Watchdog counter, sticky error flag and the registered error bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt    <= '0;
      sticky_err <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state == S_SETTLE)   tmo_cnt <= '0;
      else if (state == S_RUN) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_RUN && mul_done) begin
        rsp_err_q <= sticky_err;
      end else if (run_timeout) begin
        rsp_err_q  <= 1'b1;
        sticky_err <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign run_timeout = 1'b0;
  assign rsp_err     = 1'b0;
`endif

endmodule
